fifo_write_ctrl_rf: RTL and testbench
=====================================

// Module: fifo_write_ctrl_rf
// PURPOSE
//  Write end and storage of the 8-entry FIFO: write-pointer decoder, 8 x 32-bit register file,
//  read/write pointers, occupancy count and status/handshake flags.
//  Exposes all entries as one flat bus plus rd_ptr, which drive the read-side 8-to-1 mux
//  (entry select = rd_ptr, mux enable = rd_en).
//  One clock domain; all state updates on rising clk.
// PARAMETERS
//  WIDTH  32  data width of each entry
//  DEPTH  8   number of entries (fixed power of two; pointer width AW = 3)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        synchronous, active-high reset
//  wr_en      in   1        write request; d_in captured if accepted
//  d_in       in   32       write data
//  rd_en      in   1        read request from read side (pops entry at rd_ptr)
//  rf_data    out  256      entries flattened: [32*i+31:32*i] = entry i
//  wr_ptr     out  3        next entry to be written
//  rd_ptr     out  3        entry currently at FIFO head (read-mux select)
//  data_count out  4        occupancy 0..8
//  full       out  1        data_count == 8 (combinational from count register)
//  empty      out  1        data_count == 0 (combinational from count register)
//  wr_ack     out  1        registered: write accepted last cycle
//  wr_err     out  1        registered: write rejected last cycle (overflow)
//  rd_ack     out  1        registered: read accepted last cycle
//  rd_err     out  1        registered: read rejected last cycle (underflow)
// BEHAVIOUR
//  - Reset (reset=1 at edge): all 8 entries = 0, wr_ptr = rd_ptr = 0, data_count = 0,
//    wr_ack = wr_err = rd_ack = rd_err = 0 -> empty = 1, full = 0. Reset overrides all requests,
//    including mid-stream; in-flight data is discarded.
//  - Write accepted iff wr_en & !full (full evaluated on pre-edge count): entry[wr_ptr] <= d_in,
//    wr_ptr <= wr_ptr+1 (mod 8, 7 -> 0), wr_ack <= 1. Write decoder is one-hot from wr_ptr;
//    only that entry changes, all others hold.
//  - wr_en & full: no storage change, wr_ptr holds, wr_err <= 1, wr_ack <= 0.
//  - Read accepted iff rd_en & !empty: rd_ptr <= rd_ptr+1 (mod 8), rd_ack <= 1. Entry contents
//    are not cleared on read.
//  - rd_en & empty: rd_ptr holds, rd_err <= 1, rd_ack <= 0.
//  - Idle request: its ack/err both <= 0 (single-cycle pulses per request cycle).
//  - data_count next = count + wr_accepted - rd_accepted; never below 0 or above 8.
//  - Simultaneous wr_en & rd_en:
//      not full, not empty -> both accepted, count unchanged, both pointers advance.
//      full  -> read accepted, write rejected (wr_err), count 8 -> 7.
//      empty -> write accepted, read rejected (rd_err), count 0 -> 1.
//  - Latency: accepted write visible on rf_data and data_count the cycle after the edge;
//    read-mux output (entry[rd_ptr] while rd_en) therefore needs no extra stage.
//  - Pointer wrap: wr_ptr == rd_ptr occurs both when empty and full; status comes only from
//    data_count, never from pointer comparison.
// TESTING
//  1. Reset then idle -> empty=1, full=0, data_count=0, pointers 0, rf_data all zero, flags 0.
//  2. 8 writes d_in=32'h1..32'h8 -> wr_ack each cycle, count 1..8, full=1 after 8th,
//     wr_ptr wraps to 0, entry i = i+1.
//  3. 9th write 32'hDEAD while full -> wr_err=1, wr_ack=0, entries and count unchanged.
//  4. 8 reads -> rd_ack each cycle, rd_ptr 0..7 -> 0, count 8..0, empty=1; 9th read -> rd_err=1.
//  5. wr_en&rd_en at count=0, 3, 8 -> count becomes 1, 3, 7 with wr_err only at 8,
//     rd_err only at 0.
//  6. Assert reset with count=5 mid-burst while wr_en=1 -> next cycle count=0, pointers 0,
//     entries 0, no ack/err.

Source files
------------

// File: rtl/fifo_write_ctrl_rf.sv
// Write end and storage of an 8-entry FIFO: one-hot write decoder, register file,
// read/write pointers, occupancy count and registered handshake flags.
module fifo_write_ctrl_rf #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         d_in,
   input  logic                     rd_en,
   output logic [WIDTH*DEPTH-1:0]   rf_data,
   output logic [AW-1:0]            wr_ptr,
   output logic [AW-1:0]            rd_ptr,
   output logic [CW-1:0]            data_count,
   output logic                     full,
   output logic                     empty,
   output logic                     wr_ack,
   output logic                     wr_err,
   output logic                     rd_ack,
   output logic                     rd_err
);

   logic             wr_acc;
   logic             rd_acc;
   logic [DEPTH-1:0] wr_sel;

   // Status derives only from the count; pointers are equal both when empty and full.
   assign full   = (data_count == CW'(DEPTH));
   assign empty  = (data_count == '0);
   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;
   assign wr_sel = DEPTH'(1) << wr_ptr;

   // One register per entry; only the decoded entry loads on an accepted write.
   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [WIDTH-1:0] entry_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            entry_q <= '0;
         end else if (wr_acc && wr_sel[i]) begin
            entry_q <= d_in;
         end
      end

      assign rf_data[WIDTH*i +: WIDTH] = entry_q;
   end

   // Pointers, occupancy and single-cycle handshake pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_count <= '0;
         wr_ack     <= 1'b0;
         wr_err     <= 1'b0;
         rd_ack     <= 1'b0;
         rd_err     <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         data_count <= data_count + CW'(wr_acc) - CW'(rd_acc);
         wr_ack     <= wr_acc;
         wr_err     <= wr_en & full;
         rd_ack     <= rd_acc;
         rd_err     <= rd_en & empty;
      end
   end

endmodule

// File: tb/tb_fifo_write_ctrl_rf.sv
// Randomized and directed bench for fifo_write_ctrl_rf against a queue-based FIFO model.
module tb_fifo_write_ctrl_rf;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [31:0]   d_in = '0;
   logic          rd_en = 1'b0;
   logic [255:0]  rf_data;
   logic [2:0]    wr_ptr;
   logic [2:0]    rd_ptr;
   logic [3:0]    data_count;
   logic          full;
   logic          empty;
   logic          wr_ack;
   logic          wr_err;
   logic          rd_ack;
   logic          rd_err;

   int nchk = 0;
   int nerr = 0;

   fifo_write_ctrl_rf dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .d_in       (d_in),
      .rd_en      (rd_en),
      .rf_data    (rf_data),
      .wr_ptr     (wr_ptr),
      .rd_ptr     (rd_ptr),
      .data_count (data_count),
      .full       (full),
      .empty      (empty),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of stored words plus a memory image of the 8 slots.
   logic [31:0] q[$];
   logic [31:0] m_mem [8];
   int          m_wp = 0;
   int          m_rp = 0;
   bit          m_wack, m_werr, m_rack, m_rerr;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         for (int i = 0; i < 8; i++) m_mem[i] = '0;
         m_wp = 0; m_rp = 0;
         m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         bit wa, ra;
         wa = wr_en && (q.size() < 8);
         ra = rd_en && (q.size() > 0);
         if (ra) begin
            void'(q.pop_front());
            m_rp = (m_rp + 1) % 8;
         end
         if (wa) begin
            q.push_back(d_in);
            m_mem[m_wp] = d_in;
            m_wp = (m_wp + 1) % 8;
         end
         m_wack = wa;
         m_werr = wr_en && !wa;
         m_rack = ra;
         m_rerr = rd_en && !ra;
      end
   end

   // Compare every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (m_valid) begin
         logic [255:0] exp_rf;
         for (int i = 0; i < 8; i++) exp_rf[32*i +: 32] = m_mem[i];
         chk("rf_data", rf_data, exp_rf);
         chk("wr_ptr", 256'(wr_ptr), 256'(m_wp));
         chk("rd_ptr", 256'(rd_ptr), 256'(m_rp));
         chk("data_count", 256'(data_count), 256'(q.size()));
         chk("full", 256'(full), 256'(q.size() == 8));
         chk("empty", 256'(empty), 256'(q.size() == 0));
         chk("wr_ack", 256'(wr_ack), 256'(m_wack));
         chk("wr_err", 256'(wr_err), 256'(m_werr));
         chk("rd_ack", 256'(rd_ack), 256'(m_rack));
         chk("rd_err", 256'(rd_err), 256'(m_rerr));
         if (q.size() > 0) chk("head", 256'(rf_data[32*m_rp +: 32]), 256'(q[0]));
      end
   end

   task automatic cyc(input bit w, input logic [31:0] d, input bit r);
      wr_en = w; d_in = d; rd_en = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [255:0] seq_img;
      // Reset then idle
      reset = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      reset = 1'b0;
      cyc(0, 0, 0);
      chk("t1_count", 256'(data_count), 256'(0));
      chk("t1_empty", 256'(empty), 256'(1));
      chk("t1_full", 256'(full), 256'(0));
      chk("t1_rf", rf_data, 256'(0));
      chk("t1_flags", 256'({wr_ack, wr_err, rd_ack, rd_err}), 256'(0));

      // Eight writes fill the FIFO
      for (int i = 0; i < 8; i++) begin
         cyc(1, 32'(i + 1), 0);
         chk("t2_wr_ack", 256'(wr_ack), 256'(1));
         chk("t2_count", 256'(data_count), 256'(i + 1));
      end
      seq_img = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
      chk("t2_full", 256'(full), 256'(1));
      chk("t2_wr_ptr", 256'(wr_ptr), 256'(0));
      chk("t2_rf", rf_data, seq_img);

      // Overflow attempt
      cyc(1, 32'hDEAD, 0);
      chk("t3_wr_err", 256'(wr_err), 256'(1));
      chk("t3_wr_ack", 256'(wr_ack), 256'(0));
      chk("t3_count", 256'(data_count), 256'(8));
      chk("t3_rf", rf_data, seq_img);

      // Drain, then underflow
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 1);
         chk("t4_rd_ack", 256'(rd_ack), 256'(1));
         chk("t4_rd_ptr", 256'(rd_ptr), 256'((i + 1) % 8));
         chk("t4_count", 256'(data_count), 256'(7 - i));
      end
      chk("t4_empty", 256'(empty), 256'(1));
      cyc(0, 0, 1);
      chk("t4_rd_err", 256'(rd_err), 256'(1));
      chk("t4_rf_kept", rf_data, seq_img);

      // Simultaneous requests at count 0, 3, 8
      cyc(1, 32'hA0, 1);
      chk("t5_c0_count", 256'(data_count), 256'(1));
      chk("t5_c0_flags", 256'({wr_ack, wr_err, rd_ack, rd_err}), 256'(4'b1001));
      cyc(1, 32'hA1, 0);
      cyc(1, 32'hA2, 0);
      cyc(1, 32'hA3, 1);
      chk("t5_c3_count", 256'(data_count), 256'(3));
      chk("t5_c3_flags", 256'({wr_ack, wr_err, rd_ack, rd_err}), 256'(4'b1010));
      for (int i = 0; i < 5; i++) cyc(1, 32'(32'hB0 + i), 0);
      chk("t5_c8_pre", 256'(data_count), 256'(8));
      cyc(1, 32'hCC, 1);
      chk("t5_c8_count", 256'(data_count), 256'(7));
      chk("t5_c8_flags", 256'({wr_ack, wr_err, rd_ack, rd_err}), 256'(4'b0110));

      // Reset mid-burst at count 5
      reset = 1'b1;
      cyc(0, 0, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1, 32'(32'h50 + i), 0);
      chk("t6_pre", 256'(data_count), 256'(5));
      reset = 1'b1;
      cyc(1, 32'h77, 0);
      reset = 1'b0;
      chk("t6_count", 256'(data_count), 256'(0));
      chk("t6_ptrs", 256'({wr_ptr, rd_ptr}), 256'(0));
      chk("t6_rf", rf_data, 256'(0));
      chk("t6_flags", 256'({wr_ack, wr_err, rd_ack, rd_err}), 256'(0));

      // Randomized traffic with phase-varying bias and occasional reset
      for (int ph = 0; ph < 6; ph++) begin
         int wp, rp;
         wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
         rp = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
         for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp);
         end
      end
      reset = 1'b0;
      cyc(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
